ppi_key_matrix: RTL and testbench

Keyboard matrix controller feeding the PPI port B read path. It accepts key make/break events from a keyboard front-end (PS/2 or USB decoder) over a valid/ready handshake and queues them in a small FIFO. A sequencer applies the queued events one at a time to an active-low row array. The array is read back through the PPI's matrix_y/matrix_x pins: matrix_y comes from port C, matrix_x goes to port B.

---
 rtl/ppi_key_pkg.sv | 21 ++
 rtl/ppi_key_fifo.sv | 59 +++++
 rtl/ppi_key_matrix.sv | 178 +++++++++++++++++
 tb/tb_ppi_key_matrix.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_key_pkg.sv
// Shared types and defaults for the PPI keyboard matrix controller.
// key_event_t is the FIFO word: {row, col, is_release}.
package ppi_key_pkg;

  localparam int ROWS_DEFAULT       = 11;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] row;
    logic [2:0] col;
    logic       is_release;
  } key_event_t;

endpackage

// File: rtl/ppi_key_fifo.sv
// Small synchronous FIFO of key events with flush; head is visible on dout
// whenever the FIFO is non-empty (first-word fall-through).
module ppi_key_fifo
  import ppi_key_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  key_event_t din,
  output key_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  key_event_t  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ppi_key_matrix.sv
// Keyboard matrix controller: queues make/break events, applies them to an
// active-low row array, and serves the row selected by matrix_y to port B.
module ppi_key_matrix
  import ppi_key_pkg::*;
#(
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_row,
  input  logic [2:0] key_col,
  input  logic       key_release,
  input  logic       all_release,
  input  logic [3:0] matrix_y,
  output logic [7:0] matrix_x,
  output logic       busy
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  state_t     state_reg;
  state_t     state_next;
  key_event_t head;
  key_event_t ev_reg;
  key_event_t push_ev;
  logic [7:0] row_data_reg;
  logic [3:0] clr_cnt_reg;
  logic [7:0] matrix_x_reg;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  logic       wr_en;
  logic [3:0] wr_row;
  logic [7:0] wr_data;

  // Full 16-entry view; unimplemented rows read as all-released.
  logic [7:0] rows [16];

  assign key_ready = !fifo_full && (state_reg != CLEAR) && !all_release;
  assign fifo_push = key_valid && key_ready;
  assign push_ev   = '{row: key_row, col: key_col, is_release: key_release};
  assign busy      = (state_reg != IDLE) || !fifo_empty;
  assign matrix_x  = matrix_x_reg;

  ppi_key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (all_release),
    .din     (push_ev),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (all_release) begin
          state_next = CLEAR;
        end else if (!fifo_empty) begin
          state_next = RD;
        end
      end
      RD: begin
        state_next = all_release ? CLEAR : WR;
      end
      WR: begin
        if (all_release) begin
          state_next = CLEAR;
        end else if (!fifo_empty) begin
          state_next = RD;
        end else begin
          state_next = IDLE;
        end
      end
      CLEAR: begin
        if (!all_release && (clr_cnt_reg == LAST_ROW)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    wr_en    = 1'b0;
    wr_row   = 4'd0;
    wr_data  = 8'hFF;
    unique case (state_reg)
      RD: begin
        fifo_pop = 1'b1;
      end
      WR: begin
        wr_en               = ({1'b0, ev_reg.row} < 5'(ROWS));
        wr_row              = ev_reg.row;
        wr_data             = row_data_reg;
        wr_data[ev_reg.col] = ev_reg.is_release;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_row  = clr_cnt_reg;
        wr_data = 8'hFF;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_reg       <= '0;
      row_data_reg <= 8'hFF;
    end else if (state_reg == RD) begin
      ev_reg       <= head;
      row_data_reg <= rows[head.row];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt_reg <= 4'd0;
    end else if ((state_next == CLEAR) && ((state_reg != CLEAR) || all_release)) begin
      clr_cnt_reg <= 4'd0;
    end else if (state_reg == CLEAR) begin
      clr_cnt_reg <= clr_cnt_reg + 4'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_row
      if (gi < ROWS) begin : g_impl
        logic [7:0] row_reg;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            row_reg <= 8'hFF;
          end else if (wr_en && (wr_row == 4'(gi))) begin
            row_reg <= wr_data;
          end
        end
        assign rows[gi] = row_reg;
      end else begin : g_absent
        assign rows[gi] = 8'hFF;
      end
    end
  endgenerate

  // Forward the row being written so the readout sees it on the write edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      matrix_x_reg <= 8'hFF;
    end else if (wr_en && (wr_row == matrix_y)) begin
      matrix_x_reg <= wr_data;
    end else begin
      matrix_x_reg <= rows[matrix_y];
    end
  end

endmodule

// File: tb/tb_ppi_key_matrix.sv
// Directed bench for ppi_key_matrix: reset, press/release latency, burst,
// out-of-range rows, all_release flush, ordering and mid-operation reset.
module tb_ppi_key_matrix;

  logic       clk;
  logic       reset_n;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       key_release;
  logic       all_release;
  logic [3:0] matrix_y;
  logic [7:0] matrix_x;
  logic       busy;

  int checks_total  = 0;
  int checks_passed = 0;
  logic [7:0] exp_rows [16];

  ppi_key_matrix dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_row     (key_row),
    .key_col     (key_col),
    .key_release (key_release),
    .all_release (all_release),
    .matrix_y    (matrix_y),
    .matrix_x    (matrix_x),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_rows[i] = 8'hFF;
  endtask

  // Push one event; returns at #1 after the accepting edge with valid low.
  task automatic push(input logic [3:0] r, input logic [2:0] c, input logic rel,
                      output logic stalled);
    logic accepted;
    logic rdy;
    stalled     = 1'b0;
    accepted    = 1'b0;
    key_valid   = 1'b1;
    key_row     = r;
    key_col     = c;
    key_release = rel;
    for (int i = 0; i < 60; i++) begin
      rdy = key_ready;
      if (!rdy) stalled = 1'b1;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    key_valid = 1'b0;
    if (!accepted) chk("push_timeout", 32'd0, 32'd1);
    else if (r < 4'd11) exp_rows[r][c] = rel;
    $display("push row=%0d col=%0d release=%0d stalled=%0d accepted=%0d",
             r, c, rel, stalled, accepted);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_row(input logic [3:0] r, output logic [7:0] v);
    matrix_y = r;
    tick();
    v = matrix_x;
  endtask

  initial begin
    logic       st;
    logic       any_stall;
    logic [7:0] v;
    int         cnt;
    int         bad;
    int         seen;

    reset_n     = 1'b0;
    key_valid   = 1'b0;
    key_row     = '0;
    key_col     = '0;
    key_release = 1'b0;
    all_release = 1'b0;
    matrix_y    = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Reset state
    chk("reset_ready", 32'(key_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    for (int r = 0; r < 16; r++) begin
      read_row(4'(r), v);
      chk($sformatf("reset_row%0d", r), 32'(v), 32'hFF);
    end

    // Single press: visible exactly 3 edges after accept
    matrix_y = 4'd8;
    tick();
    push(4'd8, 3'd0, 1'b0, st);
    tick();
    tick();
    chk("press_early", 32'(matrix_x), 32'hFF);
    tick();
    chk("press_latency", 32'(matrix_x), 32'hFE);
    wait_idle();
    push(4'd8, 3'd0, 1'b1, st);
    wait_idle();
    read_row(4'd8, v);
    chk("release_row8", 32'(v), 32'hFF);

    // Burst of 8 makes on row 0
    any_stall = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      push(4'd0, 3'(c), 1'b0, st);
      any_stall |= st;
      cnt++;
    end
    chk("burst_ready_dropped", 32'(any_stall), 32'd1);
    chk("burst_accepted", 32'(cnt), 32'd8);
    wait_idle();
    read_row(4'd0, v);
    chk("burst_row0", 32'(v), 32'h00);
    push(4'd0, 3'd1, 1'b1, st);
    push(4'd0, 3'd6, 1'b1, st);
    wait_idle();
    read_row(4'd0, v);
    chk("burst_break", 32'(v), 32'h42);

    // Out-of-range row
    push(4'd12, 3'd3, 1'b0, st);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    chk("oor_busy_cycles", 32'(cnt >= 2), 32'd1);
    chk("oor_busy_done", 32'(busy), 32'd0);
    for (int r = 0; r < 11; r++) begin
      read_row(4'(r), v);
      chk($sformatf("oor_row%0d", r), 32'(v), 32'(exp_rows[r]));
    end
    read_row(4'd12, v);
    chk("oor_row12", 32'(v), 32'hFF);

    // all_release mid-burst
    push(4'd2, 3'd5, 1'b0, st);
    wait_idle();
    read_row(4'd2, v);
    chk("setup_row2", 32'(v), 32'hDF);
    matrix_y = 4'd6;
    push(4'd3, 3'd0, 1'b0, st);
    push(4'd6, 3'd7, 1'b0, st);
    push(4'd7, 3'd7, 1'b0, st);
    all_release = 1'b1;
    tick();
    all_release = 1'b0;
    chk("clear_ready_low", 32'(key_ready), 32'd0);
    model_clear();
    cnt = 0;
    bad = 0;
    while (busy && cnt < 40) begin
      if (!key_ready) begin end else bad++;
      if (matrix_x !== 8'hFF) bad++;
      tick();
      cnt++;
    end
    chk("clear_no_apply", 32'(bad), 32'd0);
    chk("clear_within_rows_plus2", 32'(cnt <= 13), 32'd1);
    chk("clear_busy_done", 32'(busy), 32'd0);
    for (int r = 0; r < 16; r++) begin
      read_row(4'(r), v);
      chk($sformatf("clear_row%0d", r), 32'(v), 32'hFF);
    end

    // Ordering: make then break of the same key ends released
    matrix_y = 4'd4;
    tick();
    push(4'd4, 3'd2, 1'b0, st);
    push(4'd4, 3'd2, 1'b1, st);
    seen = 0;
    cnt = 0;
    while (busy && cnt < 40) begin
      if (matrix_x == 8'hFB) seen = 1;
      tick();
      cnt++;
    end
    tick();
    chk("order_saw_press", 32'(seen), 32'd1);
    chk("order_row4", 32'(matrix_x), 32'hFF);

    // Reset during RD
    matrix_y = 4'd5;
    tick();
    push(4'd5, 3'd1, 1'b0, st);
    tick();
    reset_n = 1'b0;
    #2;
    chk("rst_mid_matrix_x", 32'(matrix_x), 32'hFF);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_mid_row5", 32'(matrix_x), 32'hFF);
    chk("rst_mid_busy_after", 32'(busy), 32'd0);
    chk("rst_mid_ready_after", 32'(key_ready), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
